// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic unit's serial datapaths.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } ser_state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fullsubtractor.sv
// One-bit full subtractor: D = A - B - Bin, with borrow-out.
module fullsubtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor_8bits.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first, start/busy/done handshake.
module serial_subtractor_8bits
  import arith_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             Z
);

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             brw;
  logic             a_msb;
  logic             b_msb;
  logic [CNT_W-1:0] cnt;

  logic             bit_d;
  logic             bit_bo;
  logic [WIDTH-1:0] res_next;

  fullsubtractor u_cell (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Bin  (brw),
    .D    (bit_d),
    .Bout (bit_bo)
  );

  // Result fills from the MSB end so the LSB lands at bit 0 after WIDTH shifts.
  assign res_next = {bit_d, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      brw    <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      D      <= '0;
      Bout   <= 1'b0;
      V      <= 1'b0;
      Z      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            brw   <= Bin;
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          brw    <= bit_bo;
          cnt    <= cnt + 1'b1;
          if (cnt == LastBit) begin
            // Publish on entry to FIN so the flags are valid alongside the done pulse.
            D     <= res_next;
            Bout  <= bit_bo;
            V     <= (a_msb != b_msb) && (bit_d != a_msb);
            Z     <= (res_next == '0);
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_8bits.sv
// Self-checking bench for serial_subtractor_8bits: directed table, corner sequences, random ops.
module tb_serial_subtractor_8bits;

  localparam int unsigned W = 8;
  localparam int ExpLat = W + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bout;
  logic         V;
  logic         Z;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bout;
    logic         v;
    logic         z;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         v;
    logic         z;
  } res_t;

  serial_subtractor_8bits #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .V     (V),
    .Z     (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: wide integer subtraction; borrow is the sign of the true difference.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    res_t r;
    int   diff;
    diff   = int'(a) - int'(b) - int'(bin);
    r.d    = W'(diff);
    r.bout = (diff < 0);
    r.v    = (a[W-1] != b[W-1]) && (r.d[W-1] != a[W-1]);
    r.z    = (r.d == '0);
    return r;
  endfunction

  // Issue one op from IDLE; lat = cycle index of done (start cycle = 0). Returns in IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input bit garble, output int lat);
    A     = a;
    B     = b;
    Bin   = bin;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 30) begin
      if (garble) begin
        A   = W'($urandom);
        B   = W'($urandom);
        Bin = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_res(input string name, input res_t exp, input int lat);
    check({name, "_lat"}, lat, ExpLat);
    check({name, "_D"}, D, exp.d);
    check({name, "_Bout"}, Bout, exp.bout);
    check({name, "_V"}, V, exp.v);
    check({name, "_Z"}, Z, exp.z);
    check({name, "_busy"}, busy, 0);
  endtask

  vec_t vecs[7];

  initial begin
    int   lat;
    int   cyc;
    int   ndone;
    int   drift;
    res_t e;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h33, 8'h33, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    Bin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, D, Bout, V, Z}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, lat);
      e = '{vecs[i].d, vecs[i].bout, vecs[i].v, vecs[i].z};
      check_res($sformatf("vec%0d", i), e, lat);
    end

    // Start while busy is ignored
    A = 8'h05; B = 8'h02; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 30) begin
      if (lat == 4) begin
        start = 1'b1; A = 8'hFF; B = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("busy_start_lat", lat, ExpLat);
    check("busy_start_D", D, 8'h03);
    @(posedge clk); #1;
    check("busy_start_idle", busy, 0);

    // Outputs hold through the next RUN
    A = 8'h10; B = 8'h01; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drift = 0;
    cyc   = 1;
    while (!done && cyc < 30) begin
      if (D !== 8'h03 || Bout !== 1'b0 || V !== 1'b0 || Z !== 1'b0) drift++;
      @(posedge clk); #1;
      cyc++;
    end
    check("hold_during_run", drift, 0);
    check("hold_next_D", D, 8'h0F);
    @(posedge clk); #1;

    // Reset mid-operation aborts with no done
    A = 8'h9C; B = 8'h21; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {busy, done, D, Bout, V, Z}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op(8'h20, 8'h01, 1'b0, 1'b0, lat);
    check_res("after_abort", model(8'h20, 8'h01, 1'b0), lat);

    // Start held high keeps re-triggering
    A = 8'h44; B = 8'h11; Bin = 1'b0; start = 1'b1;
    ndone = 0;
    drift = 0;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (D !== 8'h33) drift++;
      end
    end
    start = 1'b0;
    check("held_start_retrigger", ndone >= 2, 1);
    check("held_start_D", drift, 0);
    cyc = 0;
    while (busy && cyc < 15) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("held_start_drain", busy, 0);

    // Random ops with inputs scrambled during RUN
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rbin;
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      if (i == 0) begin
        ra = 8'h80; rb = 8'h00; rbin = 1'b1;
      end
      run_op(ra, rb, rbin, 1'b1, lat);
      check_res($sformatf("rand%0d", i), model(ra, rb, rbin), lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
